// File: rtl/bin_a_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    function automatic int unsigned bcd_limit(input int digits);
        int unsigned r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_a_bcd_seq_add3.sv
// Double-dabble digit corrector: nibbles of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) begin
            o_nib = i_nib + 4'd3;
        end
    end

endmodule

// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Values at or above 10**DIGITS saturate the output to all nines and flag ovf_o.
module bin_a_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                         clk_pi,
    input  logic                         rst_pi,
    input  logic                         start_pi,
    input  logic [BIN_W-1:0]             bin_pi,
    output logic [NIBBLE_W*DIGITS-1:0]   bcd_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         ovf_o
);

    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam int unsigned BCD_LIMIT = bcd_limit(DIGITS);

    bcd_state_t                        r_state;
    logic [BIN_W-1:0]                  r_bin;
    logic [DIGITS:0][NIBBLE_W-1:0]     r_scratch;
    logic [CNT_W-1:0]                  r_cnt;
    logic                              r_ovf_q;
    logic [NIBBLE_W*DIGITS-1:0]        r_bcd;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_ovf;

    logic [DIGITS:0][NIBBLE_W-1:0]     w_cor;
    logic                              w_ovf_in;

    // One corrector per digit plus the guard nibble.
    for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_scratch[g]),
            .o_nib (w_cor[g])
        );
    end

    assign w_ovf_in = (32'(bin_pi) >= BCD_LIMIT);

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            r_state   <= IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovf_q   <= 1'b0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_pi) begin
                        r_bin     <= bin_pi;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                        r_ovf_q   <= w_ovf_in;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    // A bit falling off the guard nibble can only mean overflow.
                    r_scratch <= {w_cor[DIGITS][NIBBLE_W-2:0], w_cor[DIGITS-1:0],
                                  r_bin[BIN_W-1]};
                    r_bin     <= r_bin << 1;
                    r_ovf_q   <= r_ovf_q | w_cor[DIGITS][NIBBLE_W-1];
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_bcd   <= r_ovf_q ? {DIGITS{4'h9}} : r_scratch[DIGITS-1:0];
                    r_ovf   <= r_ovf_q;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o  = r_bcd;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign ovf_o  = r_ovf;

endmodule
